// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the single arithmetic cell reused every cycle by serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell, LSB first, result shifted in from the MSB end.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic             accept;
  logic             last_bit;
  logic             settle;
  logic             bit_b;
  logic             fa_sum;
  logic             fa_cout;

  assign accept   = start && (state != ST_RUN);
  assign bit_idx  = cnt[IDX_W-1:0];
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign settle   = (cnt == CNT_W'(WIDTH));
  assign bit_b    = b_reg[bit_idx] ^ sub_reg;

  fa_cell u_fa (
    .a    (a_reg[bit_idx]),
    .b    (bit_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // NOTE: operand latches carry no reset; they are always loaded on an accepted start before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      sub_reg <= sub;
    end
  end

  // NOTE: every state register here uses <= so all updates see pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state    <= ST_RUN;
            cnt      <= '0;
            carry    <= sub | cin;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // A final RUN cycle with cnt == WIDTH only hands off to DONE, giving WIDTH+1 latency.
          if (settle) begin
            state <= ST_DONE;
          end else begin
            sum_reg <= {fa_sum, sum_reg[WIDTH-1:1]};
            carry   <= fa_cout;
            cnt     <= cnt + 1'b1;
            if (last_bit) begin
              cout_reg <= fa_cout;
              ovf_reg  <= carry ^ fa_cout;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vectors, start/reset corner cases, WIDTH=4 exhaustive sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one start request; returns at the negedge after the sampling edge.
  task automatic launch(input bit w4, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
    if (w4) begin
      a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; sub4 = sub; start4 = 1'b1;
    end else begin
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency and result; elapsed = negedges already past the start edge.
  task automatic await_result(input bit w4, input string tag, input int elapsed,
                              input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int k;
    k = elapsed;
    while (!(w4 ? done4 : done8) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, w4 ? 5 : 9);
    check({tag, " sum"}, w4 ? {28'd0, sum4} : {24'd0, sum8}, exp_sum);
    check({tag, " cout"}, w4 ? cout4 : cout8, exp_cout);
    check({tag, " overflow"}, w4 ? ovf4 : ovf8, exp_ovf);
    check({tag, " busy_in_done"}, w4 ? busy4 : busy8, 1'b0);
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1;
    {start8, cin8, sub8, a8, b8} = '0;
    {start4, cin4, sub4, a4, b4} = '0;

    #1;
    check("reset busy", busy8, 1'b0);
    check("reset done", done8, 1'b0);
    check("reset sum", sum8, 8'h00);
    check("reset cout_ovf", {cout8, ovf8}, 2'b00);
    check("reset w4 busy_done", {busy4, done4}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Plain add, then confirm done is a single pulse and the result holds.
    launch(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0);
    check("add_0f_01 busy", busy8, 1'b1);
    await_result(1'b0, "add_0f_01", 0, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    check("add_0f_01 done_pulse", done8, 1'b0);
    check("add_0f_01 idle", busy8, 1'b0);
    check("add_0f_01 held", sum8, 8'h10);

    launch(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0);
    await_result(1'b0, "add_ff_01_c1", 0, 8'h01, 1'b1, 1'b0);
    @(negedge clk);

    launch(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    await_result(1'b0, "add_7f_01", 0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);

    launch(1'b0, 8'h05, 8'h07, 1'b1, 1'b1);
    await_result(1'b0, "sub_05_07", 0, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);

    launch(1'b0, 8'h80, 8'h01, 1'b0, 1'b1);
    await_result(1'b0, "sub_80_01", 0, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);

    // A second start during RUN must be ignored.
    launch(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    await_result(1'b0, "ignore_start", 4, 8'h46, 1'b0, 1'b0);
    @(negedge clk);

    // Start accepted in the DONE cycle: old result visible, next op follows back to back.
    launch(1'b0, 8'h40, 8'h40, 1'b0, 1'b0);
    await_result(1'b0, "b2b_first", 0, 8'h80, 1'b0, 1'b1);
    launch(1'b0, 8'h03, 8'h05, 1'b0, 1'b1);
    check("b2b restart busy", busy8, 1'b1);
    await_result(1'b0, "b2b_second", 0, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset in RUN cycle 4 aborts with no done pulse.
    launch(1'b0, 8'h07, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_reset busy", busy8, 1'b1);
    check("pre_reset partial", sum8, 8'hE0);
    #1 rst = 1'b1;
    #1;
    check("async_reset busy", busy8, 1'b0);
    check("async_reset done", done8, 1'b0);
    check("async_reset sum", sum8, 8'h00);
    check("async_reset cout_ovf", {cout8, ovf8}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_done = saw_done | done8;
    end
    check("abort no_done", saw_done, 1'b0);
    launch(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0);
    await_result(1'b0, "after_reset", 0, 8'h10, 1'b0, 1'b0);
    @(negedge clk);

    // WIDTH=4 exhaustive sweep against an integer reference.
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            int bb, full;
            logic e_ovf;
            bb    = s ? (~y & 15) : y;
            full  = x + bb + (s ? 1 : c);
            e_ovf = (((x >> 3) & 1) == ((bb >> 3) & 1)) && (((full >> 3) & 1) != ((x >> 3) & 1));
            launch(1'b1, 8'(x), 8'(y), c[0], s[0]);
            await_result(1'b1, $sformatf("w4 s%0d c%0d %0h_%0h", s, c, x, y), 0,
                         8'(full & 15), full[4], e_ovf);
            @(negedge clk);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), bit-counter width (derived, not overridden).
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin an operation.
REQ-006 SHALL have port a, input, WIDTH, operand A (unsigned or two's complement).
REQ-007 SHALL have port b, input, WIDTH, operand B.
REQ-008 SHALL have port cin, input, 1, carry-in for add mode.
REQ-009 SHALL have port sub, input, 1, mode select: 0 = A+B+cin, 1 = A-B.
REQ-010 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-012 SHALL have port sum, output, WIDTH, result.
REQ-013 SHALL have port cout, output, 1, carry-out of the MSB.
REQ-014 SHALL have port overflow, output, 1, signed overflow flag.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch a, b, cin, sub, clear the bit counter and result, and go to RUN next cycle.
REQ-017 start SHALL be ignored while in RUN; latched operands SHALL NOT change mid-operation.
REQ-018 RUN SHALL process one bit per cycle, LSB first, through the full-adder cell, for exactly WIDTH cycles.
REQ-019 The carry flop SHALL initialise to cin when sub=0 and to 1 when sub=1; with sub=1, each B bit SHALL be inverted before the cell (cin ignored).
REQ-020 After the WIDTH-th RUN cycle the FSM SHALL enter DONE for exactly one cycle, then IDLE unless start is accepted.
REQ-021 Latency SHALL be WIDTH+1 cycles from the start-sampling edge to the edge at which done rises.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-023 sum, cout, overflow SHALL be valid in DONE and held unchanged until the next accepted start.
REQ-024 cout SHALL be the final carry; in sub mode cout=1 means no borrow (a >= b unsigned).
REQ-025 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-027 Simultaneous done and start SHALL accept the new operation; the old result SHALL still be visible during that DONE cycle.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, carry 0, sum 0, cout 0, overflow 0, busy 0, done 0, regardless of clk.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst release SHALL behave as from power-up.

Structure
REQ-030 State encoding (IDLE/RUN/DONE) and the default WIDTH constant SHALL live in a shared package serial_adder_pkg.
REQ-031 The one-bit sum/carry logic SHALL be a separate combinational sub-module fa_cell (ports a, b, cin, sum, cout), instantiated once.
REQ-032 Result SHALL be accumulated in a shift register filled from the MSB end, shifting right each RUN cycle.

Verification (WIDTH=8 unless stated)
REQ-033 a=8'h0F, b=8'h01, cin=0, sub=0 -> done at cycle 9, sum=8'h10, cout=0, overflow=0.
REQ-034 a=8'hFF, b=8'h01, cin=1, sub=0 -> sum=8'h01, cout=1, overflow=0; a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, overflow=1.
REQ-035 a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, overflow=1.
REQ-036 start pulsed again during RUN with different operands -> ignored, first result unchanged; start held in DONE cycle -> back-to-back op, done 9 cycles later.
REQ-037 rst asserted at RUN cycle 4 -> all outputs 0 asynchronously, no done pulse; subsequent op correct.
REQ-038 WIDTH=4 exhaustive: all a, b, cin, sub combinations -> sum/cout/overflow match reference model, latency 5.
